// File: rtl/video_frame_monitor_pkg.sv
// Shared types, widths and the CRC-16-CCITT step function used by the video frame monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_mon_pkg;

   typedef enum logic [0:0] {
      WAIT_VS = 1'b0,
      ACTIVE  = 1'b1
   } mon_state_t;

   localparam int COORD_W = 12;
   localparam int CRC_W   = 16;

   localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
   localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

   typedef logic [COORD_W-1:0] coord_t;

   // One pixel's worth of CRC: 12 data bits, MSB first, non-reflected.
   function automatic logic [CRC_W-1:0] crc16_upd12(input logic [CRC_W-1:0] crc,
                                                    input logic [11:0]      data12);
      logic [CRC_W-1:0] c;
      c = crc;
      for (int i = 11; i >= 0; i--) begin
         if (c[CRC_W-1] ^ data12[i])
            c = (c << 1) ^ CRC_POLY;
         else
            c = c << 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/video_frame_monitor_if.sv
// Display timing + pixel bus as seen by the frame monitor.
// Latency: n/a (wiring only).
// Backpressure: none; the video stream cannot be stalled.
// Ports: h_sync, v_sync, disp_enbl, red/green/blue (4 bits each).
//   master: the timing generator / pixel source; slave: the monitor.
interface video_frame_monitor_if;
   logic       h_sync;
   logic       v_sync;
   logic       disp_enbl;
   logic [3:0] red;
   logic [3:0] green;
   logic [3:0] blue;

   modport master (output h_sync, v_sync, disp_enbl, red, green, blue);
   modport slave  (input  h_sync, v_sync, disp_enbl, red, green, blue);
endinterface

// File: rtl/video_frame_monitor_crc16_pixel.sv
// Per-frame CRC-16-CCITT accumulator over 12-bit {red,green,blue} pixels.
// Latency: crc reflects a pixel on the cycle after en; init takes priority over en.
// Backpressure: none. Only compiled when FRAME_CRC_EN is defined.
// Ports: clk, rst (sync, active-high), init (reload CRC_INIT), en (fold data12), data12, crc.
`ifdef FRAME_CRC_EN
module crc16_pixel
   import video_mon_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             en,
   input  logic [11:0]      data12,
   output logic [CRC_W-1:0] crc
);

   always_ff @(posedge clk) begin
      if (rst || init)
         crc <= CRC_INIT;
      else if (en)
         crc <= crc16_upd12(crc, data12);
   end

endmodule
`endif

// File: rtl/video_frame_monitor.sv
// Recovers active-area pixel coordinates from sync/enable timing and measures every frame.
// Latency: rx_* one cycle after the pixel; frame results and frame_done one cycle after the closing v_sync edge.
// Backpressure: none; the monitor observes the stream and never stalls it.
// Ports: pixel_clk, sim_rst (sync, active-high), vid (slave side of the video bus),
//   rx_sx/rx_sy/rx_de (recovered pixel coordinates), frame_done (1-cycle pulse),
//   frame_width/frame_height/frame_crc/frame_cnt/timing_err (held results of the last completed frame).
// Build option: define FRAME_CRC_EN to compute frame_crc; otherwise frame_crc is constant zero.
module video_frame_monitor
   import video_mon_pkg::*;
#(
   parameter int   H_ACTIVE = 800,
   parameter int   V_ACTIVE = 600,
   parameter logic SYNC_POL = 1'b1
)(
   input  logic                  pixel_clk,
   input  logic                  sim_rst,
   video_frame_monitor_if.slave  vid,
   output coord_t                rx_sx,
   output coord_t                rx_sy,
   output logic                  rx_de,
   output logic                  frame_done,
   output coord_t                frame_width,
   output coord_t                frame_height,
   output logic [CRC_W-1:0]      frame_crc,
   output logic [15:0]           frame_cnt,
   output logic                  timing_err
);

   localparam coord_t SAT   = '1;
   localparam coord_t H_EXP = coord_t'(H_ACTIVE);
   localparam coord_t V_EXP = coord_t'(V_ACTIVE);

   mon_state_t       state, state_nxt;
   logic             vs_prev, in_line, err;
   coord_t           x_cnt, y_cnt, line_len;
   logic [CRC_W-1:0] crc_acc;

   logic   vs_act, hs_act, vs_edge, active, close, pix_ok, line_end;
   logic   first_line, len_bad, x_sat, y_sat, err_now;
   coord_t x_nxt, y_nxt, len_eff, height_eff;

   always_comb begin
      state_nxt  = state;
      vs_act     = (vid.v_sync == SYNC_POL);
      hs_act     = (vid.h_sync == SYNC_POL);
      vs_edge    = vs_act && (vs_prev != SYNC_POL);
      active     = (state == ACTIVE);
      close      = active && vs_edge;
      // Pixels inside vertical sync are never counted, only flagged.
      pix_ok     = active && vid.disp_enbl && !vs_act;
      // A line ends on falling disp_enbl; a line still open at the frame edge is closed here too.
      line_end   = active && in_line && (!vid.disp_enbl || vs_edge);
      first_line = (y_cnt == '0);
      len_bad    = line_end && !first_line && (x_cnt != line_len);
      x_sat      = pix_ok && (x_cnt == SAT);
      y_sat      = line_end && (y_cnt == SAT);
      err_now    = active && ((vid.disp_enbl && vs_act) ||
                              (vid.disp_enbl && hs_act) ||
                              len_bad || x_sat || y_sat);
      x_nxt      = x_sat ? x_cnt : x_cnt + coord_t'(1);
      y_nxt      = y_sat ? y_cnt : y_cnt + coord_t'(1);
      // Results at frame close must include a line that finishes on this very cycle.
      len_eff    = (line_end && first_line) ? x_cnt : line_len;
      height_eff = line_end ? y_nxt : y_cnt;
      if (vs_edge)
         state_nxt = ACTIVE;
   end

   always_ff @(posedge pixel_clk) begin
      if (sim_rst)
         state <= WAIT_VS;
      else
         state <= state_nxt;
   end

   always_ff @(posedge pixel_clk) begin
      if (sim_rst) begin
         vs_prev      <= !SYNC_POL;
         in_line      <= 1'b0;
         err          <= 1'b0;
         x_cnt        <= '0;
         y_cnt        <= '0;
         line_len     <= '0;
         rx_sx        <= '0;
         rx_sy        <= '0;
         rx_de        <= 1'b0;
         frame_done   <= 1'b0;
         frame_width  <= '0;
         frame_height <= '0;
         frame_crc    <= '0;
         frame_cnt    <= '0;
         timing_err   <= 1'b0;
      end else begin
         vs_prev    <= vid.v_sync;
         frame_done <= close;
         rx_de      <= pix_ok;
         if (pix_ok) begin
            rx_sx <= x_cnt;
            rx_sy <= y_cnt;
         end

         if (vs_edge) begin
            in_line  <= 1'b0;
            err      <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            line_len <= '0;
         end else if (active) begin
            if (err_now)
               err <= 1'b1;
            if (line_end) begin
               x_cnt   <= '0;
               y_cnt   <= y_nxt;
               in_line <= 1'b0;
               if (first_line)
                  line_len <= x_cnt;
            end else if (pix_ok) begin
               x_cnt   <= x_nxt;
               in_line <= 1'b1;
            end
         end

         if (close) begin
            frame_width  <= len_eff;
            frame_height <= height_eff;
            frame_crc    <= crc_acc;
            frame_cnt    <= frame_cnt + 16'd1;
            timing_err   <= err | err_now | (len_eff != H_EXP) | (height_eff != V_EXP);
         end
      end
   end

`ifdef FRAME_CRC_EN
   crc16_pixel u_crc (
      .clk    (pixel_clk),
      .rst    (sim_rst),
      .init   (vs_edge),
      .en     (pix_ok),
      .data12 ({vid.red, vid.green, vid.blue}),
      .crc    (crc_acc)
   );
`else
   logic unused_rgb;
   assign crc_acc    = '0;
   assign unused_rgb = ^{vid.red, vid.green, vid.blue};
`endif

endmodule

// File: tb/tb_video_frame_monitor.sv
// Scoreboarded bench for video_frame_monitor with H_ACTIVE=4, V_ACTIVE=3, positive syncs.
// Stimulus pushes expected pixel coordinates and frame results; a negedge monitor pops and compares.
// Expected CRC comes from an independent tap-wise CRC-16-CCITT model (zero when FRAME_CRC_EN is undefined).
module tb_video_frame_monitor;
   import video_mon_pkg::*;

   localparam int H = 4;
   localparam int V = 3;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
   } px_t;

   typedef struct {
      logic [11:0] w;
      logic [11:0] h;
      logic        err;
      logic [15:0] cnt;
      logic [15:0] crc;
   } frame_exp_t;

   logic pixel_clk = 1'b0;
   logic sim_rst   = 1'b1;
   always #5 pixel_clk = ~pixel_clk;

   video_frame_monitor_if vid ();

   logic [11:0] rx_sx, rx_sy, frame_width, frame_height;
   logic        rx_de, frame_done, timing_err;
   logic [15:0] frame_crc, frame_cnt;

   video_frame_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_POL(1'b1)) dut (
      .pixel_clk    (pixel_clk),
      .sim_rst      (sim_rst),
      .vid          (vid.slave),
      .rx_sx        (rx_sx),
      .rx_sy        (rx_sy),
      .rx_de        (rx_de),
      .frame_done   (frame_done),
      .frame_width  (frame_width),
      .frame_height (frame_height),
      .frame_crc    (frame_crc),
      .frame_cnt    (frame_cnt),
      .timing_err   (timing_err)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference CRC step written as explicit feedback taps at bits 0, 5 and 12.
   function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [11:0] d);
      logic [15:0] c, n;
      logic        fb;
      c = c_in;
      for (int i = 11; i >= 0; i--) begin
         fb    = c[15] ^ d[i];
         n     = c << 1;
         n[0]  = fb;
         n[5]  = c[4] ^ fb;
         n[12] = c[11] ^ fb;
         c     = n;
      end
      return c;
   endfunction

   function automatic logic [15:0] crc_exp(input logic [15:0] c);
`ifdef FRAME_CRC_EN
      return c;
`else
      return (c & 16'h0000);
`endif
   endfunction

   // Scoreboard queues and bench-side frame model.
   px_t        px_q[$];
   frame_exp_t frame_q[$];
   logic       m_open  = 1'b0;
   int         m_lines = 0;
   int         m_first_len = 0;
   logic       m_err   = 1'b0;
   logic [15:0] m_crc  = 16'hFFFF;
   logic [15:0] m_cnt  = 16'd0;

   logic [15:0] obs_crc [0:15];
   int          fd_count = 0;
   logic        prev_fd  = 1'b0;
   px_t         mp;
   frame_exp_t  mf;

   always @(negedge pixel_clk) begin
      if (rx_de) begin
         check("rx_de_expected", 32'(px_q.size() != 0), 32'd1);
         if (px_q.size() != 0) begin
            mp = px_q.pop_front();
            check("rx_sx", 32'(rx_sx), 32'(mp.x));
            check("rx_sy", 32'(rx_sy), 32'(mp.y));
         end
      end
      if (frame_done) begin
         fd_count++;
         check("frame_done_pulse", 32'(prev_fd), 32'd0);
         check("frame_done_expected", 32'(frame_q.size() != 0), 32'd1);
         if (frame_q.size() != 0) begin
            mf = frame_q.pop_front();
            check("frame_width",  32'(frame_width),  32'(mf.w));
            check("frame_height", 32'(frame_height), 32'(mf.h));
            check("timing_err",   32'(timing_err),   32'(mf.err));
            check("frame_cnt",    32'(frame_cnt),    32'(mf.cnt));
            check("frame_crc",    32'(frame_crc),    32'(mf.crc));
            obs_crc[mf.cnt[3:0]] = frame_crc;
         end
      end
      prev_fd = frame_done;
   end

   task automatic tick;
      @(posedge pixel_clk);
      #1;
   endtask

   // One v_sync pulse: closes the open frame (if any) and opens a new one.
   task automatic vs_pulse;
      frame_exp_t e;
      if (m_open) begin
         m_cnt = m_cnt + 16'd1;
         e.w   = 12'(m_first_len);
         e.h   = 12'(m_lines);
         e.err = m_err || (m_first_len != H) || (m_lines != V);
         e.cnt = m_cnt;
         e.crc = crc_exp(m_crc);
         frame_q.push_back(e);
      end
      m_open      = 1'b1;
      m_lines     = 0;
      m_first_len = 0;
      m_err       = 1'b0;
      m_crc       = 16'hFFFF;
      vid.v_sync = 1'b1;
      tick;
      vid.v_sync = 1'b0;
      tick;
      tick;
   endtask

   // One active line of n pixels of value base (pixel flip, if in range, forced to 12'hFFF),
   // followed by blanking with an h_sync pulse.
   task automatic line(input int n, input logic [11:0] base, input int flip = -1);
      logic [11:0] pix;
      px_t p;
      for (int k = 0; k < n; k++) begin
         pix = (k == flip) ? 12'hFFF : base;
         vid.disp_enbl = 1'b1;
         {vid.red, vid.green, vid.blue} = pix;
         if (m_open) begin
            p.x = 12'(k);
            p.y = 12'(m_lines);
            px_q.push_back(p);
            m_crc = crc_step(m_crc, pix);
         end
         tick;
      end
      vid.disp_enbl = 1'b0;
      {vid.red, vid.green, vid.blue} = 12'h000;
      if (m_open) begin
         if (m_lines == 0)
            m_first_len = n;
         else if (n != m_first_len)
            m_err = 1'b1;
         m_lines++;
      end
      @(posedge pixel_clk);
      @(negedge pixel_clk);
      check("rx_de_gap", 32'(rx_de), 32'd0);
      vid.h_sync = 1'b1;
      tick;
      vid.h_sync = 1'b0;
      tick;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rx_de"},        32'(rx_de),        32'd0);
      check({tag, "_frame_done"},   32'(frame_done),   32'd0);
      check({tag, "_frame_width"},  32'(frame_width),  32'd0);
      check({tag, "_frame_height"}, 32'(frame_height), 32'd0);
      check({tag, "_frame_crc"},    32'(frame_crc),    32'd0);
      check({tag, "_frame_cnt"},    32'(frame_cnt),    32'd0);
      check({tag, "_timing_err"},   32'(timing_err),   32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int fd_snap;
      vid.h_sync    = 1'b0;
      vid.v_sync    = 1'b0;
      vid.disp_enbl = 1'b0;
      vid.red       = 4'h0;
      vid.green     = 4'h0;
      vid.blue      = 4'h0;

      // Reset state.
      repeat (3) tick;
      @(negedge pixel_clk);
      check_idle_outputs("reset");
      sim_rst = 1'b0;
      tick;

      // Frame 1: three lines of four black pixels.
      vs_pulse;
      for (int l = 0; l < 3; l++) line(4, 12'h000);
      // Frame 2: short second line.
      vs_pulse;
      line(4, 12'h0F0);
      line(3, 12'h0F0);
      line(4, 12'h0F0);
      // Frame 3: clean again.
      vs_pulse;
      for (int l = 0; l < 3; l++) line(4, 12'h123);
      // Frames 4 and 5 identical, frame 6 with one pixel flipped.
      vs_pulse;
      for (int l = 0; l < 3; l++) line(4, 12'h5A3);
      vs_pulse;
      for (int l = 0; l < 3; l++) line(4, 12'h5A3);
      vs_pulse;
      line(4, 12'h5A3);
      line(4, 12'h5A3, 2);
      line(4, 12'h5A3);
      vs_pulse;
      repeat (3) tick;
`ifdef FRAME_CRC_EN
      check("crc_identical_frames", 32'(obs_crc[5] == obs_crc[4]), 32'd1);
      check("crc_flipped_pixel",    32'(obs_crc[6] != obs_crc[5]), 32'd1);
`endif

      // Frame 7 interrupted by reset after two lines.
      line(4, 12'h321);
      line(4, 12'h321);
      sim_rst = 1'b1;
      tick;
      tick;
      sim_rst = 1'b0;
      m_open  = 1'b0;
      m_cnt   = 16'd0;
      fd_snap = fd_count;
      @(negedge pixel_clk);
      check_idle_outputs("midreset");
      tick;
      line(4, 12'h321);
      check("no_done_before_vs", 32'(fd_count - fd_snap), 32'd0);
      vs_pulse;
      for (int l = 0; l < 3; l++) line(4, 12'h321);
      vs_pulse;
      repeat (4) tick;
      check("single_done_after_reset", 32'(fd_count - fd_snap), 32'd1);

      check("px_queue_drained",    32'(px_q.size()),    32'd0);
      check("frame_queue_drained", 32'(frame_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
